// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: auto-baud detector for the UART receive path.
// Measures 0x55 sync low pulses, picks a baud code, then enables RX.
module uart_baud_ctrl #(
  parameter int CLK_FREQ    = 100000000,
  parameter int LOCK_PULSES = 4,
  parameter int QUIET_BITS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       relock,
  output logic [2:0] baud_set,
  output logic       rx_en,
  output logic       locked,
  output logic       lock_done
);

  localparam int N0 = CLK_FREQ / 9600;
  localparam int N1 = CLK_FREQ / 19200;
  localparam int N2 = CLK_FREQ / 38400;
  localparam int N3 = CLK_FREQ / 57600;
  localparam int N4 = CLK_FREQ / 115200;

  localparam int WW = 17;
  localparam int TW = $clog2(QUIET_BITS * N0 + 1);

  localparam logic [WW-1:0] TH0  = WW'((N0 + N1) / 2);
  localparam logic [WW-1:0] TH1  = WW'((N1 + N2) / 2);
  localparam logic [WW-1:0] TH2  = WW'((N2 + N3) / 2);
  localparam logic [WW-1:0] TH3  = WW'((N3 + N4) / 2);
  localparam logic [WW-1:0] WMIN = WW'(3 * N4 / 4);
  localparam logic [WW-1:0] WMAX = WW'(5 * N0 / 4);

  localparam logic [TW-1:0] QL0 = TW'(QUIET_BITS * N0 - 1);
  localparam logic [TW-1:0] QL1 = TW'(QUIET_BITS * N1 - 1);
  localparam logic [TW-1:0] QL2 = TW'(QUIET_BITS * N2 - 1);
  localparam logic [TW-1:0] QL3 = TW'(QUIET_BITS * N3 - 1);
  localparam logic [TW-1:0] QL4 = TW'(QUIET_BITS * N4 - 1);

  localparam logic [2:0] LP = 3'(LOCK_PULSES);

  typedef enum logic [2:0] {
    HUNT,
    LOW,
    CHECK,
    QUIET,
    LOCKED
  } state_t;

  state_t        state;
  logic          s1, rs, rs_prev;
  logic          fall, rise;
  logic [WW-1:0] w;
  logic [TW-1:0] timer, qlim;
  logic [2:0]    match_cnt, cand, code, cnt_nx;
  logic          w_ok;

  // Two-flop synchronizer plus edge history; idle line is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b1;
      rs      <= 1'b1;
      rs_prev <= 1'b1;
    end else begin
      s1      <= rx;
      rs      <= s1;
      rs_prev <= rs;
    end
  end

  assign fall  = rs_prev & ~rs;
  assign rise  = ~rs_prev & rs;
  assign rx_en = locked;

  // Classify the measured width and compute the next match count
  always_comb begin
    w_ok = (w >= WMIN) && (w <= WMAX);
    if (w >= TH0)      code = 3'd0;
    else if (w >= TH1) code = 3'd1;
    else if (w >= TH2) code = 3'd2;
    else if (w >= TH3) code = 3'd3;
    else               code = 3'd4;
    if (match_cnt == 3'd0 || code == cand)
      cnt_nx = match_cnt + 3'd1;
    else
      cnt_nx = 3'd1;
  end

  // Quiet window length for the candidate code
  always_comb begin
    qlim = QL4;
    unique case (cand)
      3'd0:    qlim = QL0;
      3'd1:    qlim = QL1;
      3'd2:    qlim = QL2;
      3'd3:    qlim = QL3;
      default: qlim = QL4;
    endcase
  end

  // Measurement / lock state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      match_cnt <= 3'd0;
      cand      <= 3'd0;
      w         <= '0;
      timer     <= '0;
      baud_set  <= 3'd0;
      locked    <= 1'b0;
      lock_done <= 1'b0;
    end else if (relock) begin
      state     <= HUNT;
      match_cnt <= 3'd0;
      w         <= '0;
      timer     <= '0;
      locked    <= 1'b0;
      lock_done <= 1'b0;
    end else begin
      lock_done <= 1'b0;
      unique case (state)
        HUNT: begin
          if (fall) begin
            w     <= WW'(1);
            state <= LOW;
          end
        end
        LOW: begin
          if (rise)
            state <= CHECK;
          else if (w != '1)
            w <= w + 1'b1;
        end
        CHECK: begin
          timer <= '0;
          if (!w_ok) begin
            match_cnt <= 3'd0;
            state     <= HUNT;
          end else begin
            cand      <= code;
            match_cnt <= cnt_nx;
            state     <= (cnt_nx == LP) ? QUIET : HUNT;
          end
        end
        QUIET: begin
          if (!rs) begin
            timer <= '0;
          end else if (timer == qlim) begin
            baud_set  <= cand;
            locked    <= 1'b1;
            lock_done <= 1'b1;
            state     <= LOCKED;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LOCKED: begin
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Auto-baud controller for the UART receive path. It watches the raw serial line while the receiver is disabled and measures low-pulse widths of a host-sent 0x55 sync character. It classifies those widths into one of the five supported baud codes, drives the receiver's baud-select input, and enables the receiver once the line has gone quiet. It sits between the board RX pin and the UART receiver, and owns the receiver's baud configuration and enable.

## Interface
- CLK_FREQ, 100000000, system clock frequency in Hz; nominal bit widths are N_k = CLK_FREQ/baud_k for codes 0..4 = 9600/19200/38400/57600/115200.
- LOCK_PULSES, 4, number of consecutive low pulses with the same classification required to lock (range 1..5).
- QUIET_BITS, 10, number of idle-high bit times required after the last qualifying pulse.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  raw serial line, asynchronous to clk.
- relock  in  1  one-cycle request to drop lock and re-measure.
- baud_set  out  3  baud code to the receiver, 0..4.
- rx_en  out  1  receiver enable; high only in LOCKED.
- locked  out  1  lock status; equals rx_en.
- lock_done  out  1  one-cycle pulse on entry to LOCKED.

## Operation
- rx passes through a 2-flop synchronizer to give rs. A fall is (rs_prev=1 and rs=0); a rise is the reverse.
- Width W is the number of consecutive cycles rs is sampled 0. The fall cycle counts as 1. W is held in a 17-bit counter that saturates.
- Classification of a completed pulse, with N0=10416, N1=5208, N2=2604, N3=1736, N4=868 at the default CLK_FREQ:
  - Valid range is 3*N4/4 ≤ W ≤ 5*N0/4, i.e. 651..13020. Anything else is discarded.
  - Thresholds are arithmetic midpoints of adjacent N: 7812, 3906, 2170, 1302.
  - W ≥ 7812 gives code 0; W ≥ 3906 gives code 1; W ≥ 2170 gives code 2; W ≥ 1302 gives code 3; otherwise code 4.
- States:
  - HUNT: waits for a fall, then goes to LOW.
  - LOW: counts W. On a rise it goes to CHECK.
  - CHECK (1 cycle):
    - Invalid W: clear match_cnt, go to HUNT.
    - Valid code equal to cand (or match_cnt=0): set cand=code and increment match_cnt.
    - Valid code different from cand: set cand=code and match_cnt=1.
    - If match_cnt reaches LOCK_PULSES: go to QUIET. Otherwise go to HUNT.
  - QUIET: the timer counts cycles with rs=1. Any fall restarts the timer at 0 and stays in QUIET. When the timer reaches QUIET_BITS*N_cand−1, load baud_set=cand and go to LOCKED.
  - LOCKED: rx_en=locked=1. The line is ignored. This state is left only on relock or rst.
- Priority:
  - relock (any state) → HUNT next cycle, with match_cnt=0 and rx_en/locked=0. baud_set holds its last locked value.
  - rst overrides everything.
- baud_set changes only on the QUIET→LOCKED transition, so the receiver never sees a baud change while enabled.
- The constants N_k and the thresholds are elaboration-time expressions of CLK_FREQ. No runtime dividers are used.

## Timing
- Reset values:
  - State HUNT; match_cnt, cand, W and the timer all 0.
  - baud_set=0, rx_en=0, locked=0, lock_done=0.
- Synchronizer latency: 2 cycles from rx to rs. A fall on rx is seen 2–3 cycles later.
- CHECK occurs 1 cycle after the rise cycle. The HUNT re-arm is ready on the following cycle, so back-to-back pulses separated by ≥2 high cycles are all measured.
- Lock latency: from the rise that ends the LOCK_PULSES-th qualifying pulse, QUIET is entered 2 cycles later. locked/rx_en/lock_done assert exactly QUIET_BITS*N_cand cycles after QUIET entry, assuming no fall in that window.
- lock_done is high for exactly one cycle, coincident with the first cycle of locked=1.
- A relock in cycle t gives locked=0 in cycle t+1.
- rst asserted mid-LOW or mid-QUIET: outputs go to reset values immediately (asynchronously), and the partial measurement is lost.

## Test plan
- Reset: hold rst 5 cycles with rx toggling → baud_set=0, rx_en=0, locked=0, lock_done=0 throughout; state HUNT after release.
- 0x55 at 868 clk/bit, then idle high → locked=1 and baud_set=4 exactly 8680 cycles after the 4th low pulse's CHECK+1. lock_done is a single-cycle pulse. A further 0x55 sent while locked does not change baud_set.
- 0x55 at 10416 clk/bit → baud_set=0 and locked after 104160 quiet cycles. Widths of 7812 and 7811 classify as code 0 and code 1 respectively.
- Mixed pulses of 868, 868, 1736, 1736, 1736, 1736 → no lock before the 6th pulse; lock then completes with baud_set=3.
- Glitch of 100 cycles low, then a break of 20000 cycles low, each followed by idle → both discarded, match_cnt=0, locked stays 0.
- Lock at code 4, then pulse relock → locked=0 next cycle with baud_set still 4. Re-sync at 2604 clk/bit → baud_set=2. Assert rst during the 3rd pulse of a new sync → all outputs at reset values at once.
